ap_ctrl_sampler: RTL

// - Synthesizable front end for the dataflow status monitors. Watches one block-level ap_ctrl_hs interface and

---
 rtl/ap_ctrl_sampler.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ap_ctrl_sampler.sv
// ap_ctrl_sampler
//   Front end for the dataflow status monitors. Watches one block-level
//   ap_ctrl_hs handshake, measures every transaction (start cycle, latency,
//   start-to-start interval) and queues one record per transaction in a small
//   first-word fall-through FIFO read over a valid/ready port.
//
//   Optional feature: define AP_CTRL_STALL_EN to append an LSB-side stall
//   field (cycles spent waiting for ap_continue after ap_done).
//
// Ports
//   clock, reset          single clock (posedge), asynchronous active-high reset
//   ap_start, ap_ready    monitored block start / ready (ready is observed only)
//   ap_done, ap_continue  monitored block done / continue (tie continue to 1 if absent)
//   finish                end-of-run request, sticky once seen
//   rec_valid, rec_ready  record handshake to the status dumper
//   rec_data              {partial, txn_id, start_cyc, latency, interval[, stall]}
//   busy                  a transaction is in flight
//   overflow              sticky: a record was dropped because the FIFO was full
//   drained               flushed and FIFO empty
module ap_ctrl_sampler #(
  parameter int CNT_W = 32,
  parameter int ID_W  = 16,
  parameter int DEPTH = 8,
`ifdef AP_CTRL_STALL_EN
  parameter int REC_W = 1 + ID_W + 4 * CNT_W  // derived, do not override
`else
  parameter int REC_W = 1 + ID_W + 3 * CNT_W  // derived, do not override
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [REC_W-1:0] rec_data,
  output logic             busy,
  output logic             overflow,
  output logic             drained
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_CONT, FLUSHED} state_t;

  state_t           state;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] start_cyc;
  logic [CNT_W-1:0] interval;
  logic [CNT_W-1:0] lat_cnt;     // cycles of the transaction before the current one
  logic [CNT_W-1:0] lat_now;     // latency if the record closed this cycle
  logic [ID_W-1:0]  txn_id;
  logic             have_prev;   // a previous start exists, interval is meaningful
  logic             close_req;
  logic             rec_push;
  logic             rec_partial;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic [REC_W-1:0] push_data;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [REC_W-1:0] mem [DEPTH];

  // ap_ready carries no information the record needs; it is only watched.
  logic unused_ap_ready;
  assign unused_ap_ready = ap_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  assign busy    = (state == BUSY) || (state == WAIT_CONT);
  assign drained = (state == FLUSHED) && (count == '0);
  assign lat_now = sat_inc(lat_cnt);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    close_req = 1'b0;
    case (state)
      BUSY:      close_req = ap_done && ap_continue;
      WAIT_CONT: close_req = ap_continue;
      default:   close_req = 1'b0;
    endcase
  end

  // A finish while in flight emits the record early, marked partial.
  assign rec_push    = close_req || (busy && finish);
  assign rec_partial = !close_req;

`ifdef AP_CTRL_STALL_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_now;
  logic             start_evt;

  assign stall_now = (state == WAIT_CONT) ? sat_inc(stall_cnt) : stall_cnt;
  assign start_evt = !finish && ap_start && ((state == IDLE) || close_req);
  assign push_data = {rec_partial, txn_id, start_cyc, lat_now, interval, stall_now};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (start_evt) begin
      stall_cnt <= '0;
    end else if (state == WAIT_CONT) begin
      stall_cnt <= stall_now;
    end
  end
`else
  assign push_data = {rec_partial, txn_id, start_cyc, lat_now, interval};
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cyc       <= '0;
      start_cyc <= '0;
      interval  <= '0;
      lat_cnt   <= '0;
      txn_id    <= '0;
      have_prev <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      cyc <= sat_inc(cyc);

      // The id advances even when the record is dropped, so gaps reveal losses.
      if (rec_push) begin
        txn_id <= txn_id + ID_W'(1);
        if (!push_ok) overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (finish) begin
            state <= FLUSHED;
          end else if (ap_start) begin
            state     <= BUSY;
            start_cyc <= cyc;
            interval  <= have_prev ? cyc - start_cyc : '0;
            have_prev <= 1'b1;
            lat_cnt   <= CNT_ONE;  // the start cycle itself is counted
          end
        end
        BUSY, WAIT_CONT: begin
          if (finish) begin
            state <= FLUSHED;
          end else if (close_req) begin
            if (ap_start) begin
              // Back-to-back: the new transaction begins on the next cycle.
              state     <= BUSY;
              start_cyc <= sat_inc(cyc);
              interval  <= sat_inc(cyc) - start_cyc;
              lat_cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            lat_cnt <= lat_now;
            if ((state == BUSY) && ap_done) state <= WAIT_CONT;
          end
        end
        default: ;  // FLUSHED is terminal until reset
      endcase
    end
  end

  // Record FIFO, first-word fall-through. A pop frees a slot for a push in
  // the same cycle, so a full FIFO being read never drops.
  assign rec_valid = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = rec_valid && rec_ready;
  assign push_ok   = rec_push && (!full || pop);
  assign rec_data  = rec_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; pointers and count define validity, and rec_data is gated by rec_valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule
